read_response_arbiter: RTL and testbench

Interconnect R-channel return-path arbiter, the responder-side counterpart of the AR-channel request arbiter. Each slave's pending read-data burst is steered to the master encoded in the upper bits of its RID. One independent round-robin arbiter per master picks among the slaves targeting that master and holds the path until the burst's last beat completes. It produces per-master slave-select and valid, and per-slave grant and ready; the data and resp mux is external and driven by `Mx_Rsel`.

---
 rtl/axi_ic_pkg.sv | 14 +
 rtl/r_dest_arbiter.sv | 80 ++++++++
 rtl/read_response_arbiter.sv | 88 ++++++++
 tb/tb_read_response_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_ic_pkg.sv
// Shared interconnect constants and arbiter state encoding (AR/AW/R arbiters).
package axi_ic_pkg;

    localparam int M      = 2;
    localparam int S      = 2;
    localparam int MSEL_W = $clog2(M);
    localparam int SSEL_W = $clog2(S);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/r_dest_arbiter.sv
// Round-robin owner selection for one master's read-data return path.
//
//   state | meaning
//   IDLE  | no slave owns this master; scan requesters from rr_ptr
//   BUSY  | owner_q holds the path until its Rlast beat is accepted
module r_dest_arbiter
    import axi_ic_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [S-1:0]      req_i,
    input  logic [S-1:0]      rvalid_i,
    input  logic [S-1:0]      rlast_i,
    input  logic              mready_i,
    output logic              busy_o,
    output logic [SSEL_W-1:0] owner_o,
    output logic [S-1:0]      grant_o
);

    arb_state_e        state_q, state_d;
    logic [SSEL_W-1:0] owner_q, owner_d;
    logic [SSEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SSEL_W-1:0] cand;
    logic              found;

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Pick the first requester at or after rr_ptr; release on the accepted last beat.
    // The pointer arithmetic wraps naturally because S is a power of two.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        found    = 1'b0;
        cand     = '0;
        case (state_q)
            IDLE: begin
                for (int i = 0; i < S; i++) begin
                    cand = rr_ptr_q + SSEL_W'(i);
                    if (!found && req_i[cand]) begin
                        found   = 1'b1;
                        owner_d = cand;
                    end
                end
                if (found) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (rvalid_i[owner_q] && mready_i && rlast_i[owner_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = owner_q + SSEL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant is a decode of registered state, so it changes only on the clock.
    always_comb begin
        busy_o  = (state_q == BUSY);
        owner_o = owner_q;
        grant_o = '0;
        for (int s = 0; s < S; s++) begin
            grant_o[s] = busy_o && (owner_q == SSEL_W'(s));
        end
    end

endmodule

// File: rtl/read_response_arbiter.sv
// R-channel return-path arbiter: routes each slave's read burst to the master
// named in the upper RID bits, one independent round-robin arbiter per master.
module read_response_arbiter
    import axi_ic_pkg::*;
#(
    parameter int ID_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                S0_Rvalid,
    input  logic                S1_Rvalid,
    input  logic [ID_WIDTH-1:0] S0_Rid,
    input  logic [ID_WIDTH-1:0] S1_Rid,
    input  logic                S0_Rlast,
    input  logic                S1_Rlast,
    output logic                S0_Rgrant,
    output logic                S1_Rgrant,
    output logic                S0_Rready,
    output logic                S1_Rready,
    input  logic                M0_Rready,
    input  logic                M1_Rready,
    output logic                M0_Rvalid,
    output logic                M1_Rvalid,
    output logic [SSEL_W-1:0]   M0_Rsel,
    output logic [SSEL_W-1:0]   M1_Rsel
);

    logic [S-1:0]      s_rvalid, s_rlast, s_grant, s_rready;
    logic [MSEL_W-1:0] s_dest [S];
    logic [M-1:0]      m_rready, m_busy, m_rvalid;
    logic [S-1:0]      m_req [M];
    logic [S-1:0]      m_gnt [M];
    logic [SSEL_W-1:0] m_owner [M];
    logic              unused_rid_bits;

    assign s_rvalid  = {S1_Rvalid, S0_Rvalid};
    assign s_rlast   = {S1_Rlast, S0_Rlast};
    assign m_rready  = {M1_Rready, M0_Rready};
    assign s_dest[0] = S0_Rid[ID_WIDTH-1 -: MSEL_W];
    assign s_dest[1] = S1_Rid[ID_WIDTH-1 -: MSEL_W];
    assign unused_rid_bits = ^{S0_Rid[ID_WIDTH-MSEL_W-1:0], S1_Rid[ID_WIDTH-MSEL_W-1:0]};

    // A slave that already owns a path is masked, so a mid-burst RID change
    // cannot make it request a second master.
    always_comb begin
        for (int m = 0; m < M; m++) begin
            for (int s = 0; s < S; s++) begin
                m_req[m][s] = s_rvalid[s] && (s_dest[s] == MSEL_W'(m)) && !s_grant[s];
            end
        end
    end

    for (genvar m = 0; m < M; m++) begin : g_arb
        r_dest_arbiter u_arb (
            .clk_i    (clk),
            .rst_i    (rst),
            .req_i    (m_req[m]),
            .rvalid_i (s_rvalid),
            .rlast_i  (s_rlast),
            .mready_i (m_rready[m]),
            .busy_o   (m_busy[m]),
            .owner_o  (m_owner[m]),
            .grant_o  (m_gnt[m])
        );
    end

    // The granting arbiter's grant bit is the latched destination: ready comes
    // from the master that owns the slave, whatever the current RID says.
    always_comb begin
        s_grant  = '0;
        s_rready = '0;
        for (int m = 0; m < M; m++) begin
            s_grant  = s_grant | m_gnt[m];
            s_rready = s_rready | (m_gnt[m] & {S{m_rready[m]}});
            m_rvalid[m] = m_busy[m] && s_rvalid[m_owner[m]];
        end
    end

    assign S0_Rgrant = s_grant[0];
    assign S1_Rgrant = s_grant[1];
    assign S0_Rready = s_rready[0];
    assign S1_Rready = s_rready[1];
    assign M0_Rvalid = m_rvalid[0];
    assign M1_Rvalid = m_rvalid[1];
    assign M0_Rsel   = m_owner[0];
    assign M1_Rsel   = m_owner[1];

endmodule

// File: tb/tb_read_response_arbiter.sv
// Directed bench for read_response_arbiter with a small burst-counting slave model.
module tb_read_response_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       S0_Rvalid = 1'b0, S1_Rvalid = 1'b0;
    logic [3:0] S0_Rid = 4'b0000, S1_Rid = 4'b0000;
    logic       S0_Rlast, S1_Rlast;
    logic       S0_Rgrant, S1_Rgrant, S0_Rready, S1_Rready;
    logic       M0_Rready = 1'b0, M1_Rready = 1'b0;
    logic       M0_Rvalid, M1_Rvalid;
    logic       M0_Rsel, M1_Rsel;

    int checks = 0;
    int errors = 0;
    int cnt0 = 0, cnt1 = 0;
    int blen0 = 4, blen1 = 4;
    int beats0 = 0, beats1 = 0;
    int base;
    logic [7:0] exp_g0, exp_g1, exp_sel;

    read_response_arbiter #(.ID_WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .S0_Rvalid (S0_Rvalid),
        .S1_Rvalid (S1_Rvalid),
        .S0_Rid    (S0_Rid),
        .S1_Rid    (S1_Rid),
        .S0_Rlast  (S0_Rlast),
        .S1_Rlast  (S1_Rlast),
        .S0_Rgrant (S0_Rgrant),
        .S1_Rgrant (S1_Rgrant),
        .S0_Rready (S0_Rready),
        .S1_Rready (S1_Rready),
        .M0_Rready (M0_Rready),
        .M1_Rready (M1_Rready),
        .M0_Rvalid (M0_Rvalid),
        .M1_Rvalid (M1_Rvalid),
        .M0_Rsel   (M0_Rsel),
        .M1_Rsel   (M1_Rsel)
    );

    always #5 clk = ~clk;

    // Slaves mark the last beat of a blenX-beat burst and count accepted beats.
    assign S0_Rlast = (cnt0 == blen0 - 1);
    assign S1_Rlast = (cnt1 == blen1 - 1);

    always @(posedge clk) begin
        if (rst) begin
            cnt0 <= 0;
            cnt1 <= 0;
        end else begin
            if (S0_Rvalid && S0_Rready) begin
                beats0 <= beats0 + 1;
                cnt0   <= (cnt0 == blen0 - 1) ? 0 : cnt0 + 1;
            end
            if (S1_Rvalid && S1_Rready) begin
                beats1 <= beats1 + 1;
                cnt1   <= (cnt1 == blen1 - 1) ? 0 : cnt1 + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held with S0 requesting M0.
        S0_Rvalid = 1'b1;
        M0_Rready = 1'b1;
        M1_Rready = 1'b1;
        blen0 = 4;
        repeat (3) tick();
        chk("rst_s0_grant", 32'(S0_Rgrant), 32'd0);
        chk("rst_s1_grant", 32'(S1_Rgrant), 32'd0);
        chk("rst_m0_sel",   32'(M0_Rsel),   32'd0);
        chk("rst_m1_sel",   32'(M1_Rsel),   32'd0);
        chk("rst_m0_valid", 32'(M0_Rvalid), 32'd0);
        chk("rst_m1_valid", 32'(M1_Rvalid), 32'd0);
        chk("rst_s0_ready", 32'(S0_Rready), 32'd0);

        // Single 4-beat burst S0 -> M0.
        rst = 1'b0;
        base = beats0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("single_grant", 32'(S0_Rgrant), 32'(i < 4));
            if (i < 4) begin
                chk("single_sel",   32'(M0_Rsel),   32'd0);
                chk("single_valid", 32'(M0_Rvalid), 32'd1);
            end
            if (i == 4) S0_Rvalid = 1'b0;
        end
        chk("single_beats", 32'(beats0 - base), 32'd4);

        // Contention: both slaves continuously target M0 with 2-beat bursts.
        blen0 = 2;
        blen1 = 2;
        S0_Rid = 4'b0000;
        S1_Rid = 4'b0000;
        S0_Rvalid = 1'b1;
        S1_Rvalid = 1'b1;
        do_reset();
        exp_g0  = 8'b1100_0011;
        exp_g1  = 8'b0001_1000;
        exp_sel = 8'b0011_1000;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("cont_s0_grant", 32'(S0_Rgrant), 32'(exp_g0[i]));
            chk("cont_s1_grant", 32'(S1_Rgrant), 32'(exp_g1[i]));
            chk("cont_m0_sel",   32'(M0_Rsel),   32'(exp_sel[i]));
        end

        // Parallel: S0 -> M0 and S1 -> M1 in the same cycle.
        blen0 = 3;
        blen1 = 3;
        S1_Rid = 4'b1000;
        M1_Rready = 1'b0;
        do_reset();
        tick();
        chk("par_s0_grant", 32'(S0_Rgrant), 32'd1);
        chk("par_s1_grant", 32'(S1_Rgrant), 32'd1);
        chk("par_m0_sel",   32'(M0_Rsel),   32'd0);
        chk("par_m1_sel",   32'(M1_Rsel),   32'd1);
        chk("par_m0_valid", 32'(M0_Rvalid), 32'd1);
        chk("par_m1_valid", 32'(M1_Rvalid), 32'd1);
        chk("par_s0_ready", 32'(S0_Rready), 32'd1);
        chk("par_s1_ready", 32'(S1_Rready), 32'd0);
        M1_Rready = 1'b1;
        #1;
        chk("par_s1_ready_on", 32'(S1_Rready), 32'd1);

        // Backpressure and mid-burst valid drop on a 3-beat S0 burst.
        S0_Rvalid = 1'b0;
        S1_Rvalid = 1'b0;
        S1_Rid = 4'b0000;
        blen0 = 3;
        do_reset();
        S0_Rvalid = 1'b1;
        M0_Rready = 1'b0;
        tick();
        base = beats0;
        chk("stall_grant",    32'(S0_Rgrant), 32'd1);
        chk("stall_m0_valid", 32'(M0_Rvalid), 32'd1);
        chk("stall_s0_ready", 32'(S0_Rready), 32'd0);
        tick();
        chk("stall_nobeat", 32'(beats0 - base), 32'd0);
        chk("stall_hold",   32'(S0_Rgrant),     32'd1);
        S0_Rvalid = 1'b0;
        M0_Rready = 1'b1;
        #1;
        chk("drop_m0_valid", 32'(M0_Rvalid), 32'd0);
        chk("drop_s0_ready", 32'(S0_Rready), 32'd1);
        tick();
        chk("drop_hold",   32'(S0_Rgrant),     32'd1);
        chk("drop_nobeat", 32'(beats0 - base), 32'd0);
        S0_Rvalid = 1'b1;
        tick();
        tick();
        chk("stall_two_beats", 32'(beats0 - base), 32'd2);
        M0_Rready = 1'b0;
        tick();
        chk("last_stall_hold",  32'(S0_Rgrant),     32'd1);
        chk("last_stall_beats", 32'(beats0 - base), 32'd2);
        M0_Rready = 1'b1;
        tick();
        chk("last_release", 32'(S0_Rgrant),     32'd0);
        chk("last_beats",   32'(beats0 - base), 32'd3);

        // Mid-burst RID flip keeps the M0 route; then a mid-burst reset.
        blen0 = 4;
        M1_Rready = 1'b0;
        tick();
        chk("flip_grant", 32'(S0_Rgrant), 32'd1);
        chk("flip_sel",   32'(M0_Rsel),   32'd0);
        S0_Rid = 4'b1000;
        #1;
        chk("flip_s0_ready", 32'(S0_Rready), 32'd1);
        chk("flip_m0_valid", 32'(M0_Rvalid), 32'd1);
        chk("flip_m1_valid", 32'(M1_Rvalid), 32'd0);
        tick();
        chk("flip_hold",     32'(S0_Rgrant), 32'd1);
        chk("flip_m1_idle",  32'(M1_Rvalid), 32'd0);
        rst = 1'b1;
        tick();
        chk("mrst_grant",    32'(S0_Rgrant), 32'd0);
        chk("mrst_m0_valid", 32'(M0_Rvalid), 32'd0);
        chk("mrst_s0_ready", 32'(S0_Rready), 32'd0);
        rst = 1'b0;
        S0_Rid = 4'b0000;
        S1_Rid = 4'b0000;
        S1_Rvalid = 1'b1;
        tick();
        chk("mrst_ptr_s0", 32'(S0_Rgrant), 32'd1);
        chk("mrst_ptr_s1", 32'(S1_Rgrant), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
